// File: rtl/count_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 16;

    // Returns a mask with the low w bits set, used to build the preset value.
    function automatic logic [63:0] ones_mask(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (one << w) - one;
    endfunction

endpackage

// File: rtl/count_down_next.sv
// Combinational next-count and terminal-count logic for the down-counter.
module count_down_next
    import count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  state_e             state,
    input  logic [WIDTH-1:0]   count_q,
    input  logic [WIDTH-1:0]   reload_q,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic               preset,
    input  logic               enable,
    input  logic               auto_reload,
    output logic [WIDTH-1:0]   count_d,
    output logic               tc,
    output logic               zero_in_run
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(ones_mask(WIDTH));
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic in_run;
    logic step;

    // Priority load > preset > decrement; a zero count in RUN is parked at zero.
    always_comb begin
        in_run      = (state == RUN);
        step        = in_run && !load && !preset;
        tc          = step && enable && (count_q == ONE);
        zero_in_run = step && (count_q == ZERO);
        count_d     = count_q;
        if (load) begin
            count_d = load_value;
        end else if (preset) begin
            count_d = ALL_ONES;
        end else if (in_run && enable && (count_q != ZERO)) begin
            if (count_q == ONE) begin
                count_d = auto_reload ? reload_q : ZERO;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

endmodule

// File: rtl/count_down_timer.sv
// Loadable down-counter/timer with auto-reload and a valid/ready expiry event.
module count_down_timer
    import count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic               preset,
    input  logic               enable,
    input  logic               auto_reload,
    output logic [WIDTH-1:0]   count,
    output logic               running,
    output logic               tc,
    output logic               expire_valid,
    input  logic               expire_ready,
    output logic               overrun
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic               running_q, running_d;
    logic               expire_valid_q, expire_valid_d;
    logic               overrun_q, overrun_d;
    logic               zero_in_run;

    count_down_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .state       (state_q),
        .count_q     (count_q),
        .reload_q    (reload_q),
        .load        (load),
        .load_value  (load_value),
        .preset      (preset),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count_d     (count_d),
        .tc          (tc),
        .zero_in_run (zero_in_run)
    );

    // Next state, reload register and event handshake for the coming cycle.
    always_comb begin
        state_d        = state_q;
        reload_d       = reload_q;
        overrun_d      = overrun_q;
        expire_valid_d = tc || (expire_valid_q && !expire_ready);
        if (load) begin
            reload_d  = load_value;
            overrun_d = 1'b0;
            state_d   = (load_value != '0) ? RUN : IDLE;
        end else if (!preset && state_q == RUN) begin
            if (zero_in_run || (tc && !auto_reload)) begin
                state_d = EXPIRED;
            end
        end
        if (tc && expire_valid_q && !expire_ready) begin
            overrun_d = 1'b1;
        end
        running_d = (state_d == RUN);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            reload_q       <= '0;
            running_q      <= 1'b0;
            expire_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            reload_q       <= reload_d;
            running_q      <= running_d;
            expire_valid_q <= expire_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign count        = count_q;
    assign running      = running_q;
    assign expire_valid = expire_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Self-checking bench for count_down_timer: vector table, corner sequences, random run.
module tb_count_down_timer;

    localparam int W = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] load_value;
        logic         preset;
        logic         enable;
        logic         auto_reload;
        logic         expire_ready;
    } stim_t;

    typedef struct {
        stim_t        stim;
        logic         exp_tc;
        logic [W-1:0] exp_count;
        logic         exp_running;
        logic         exp_valid;
        logic         exp_overrun;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, load, preset, enable, auto_reload, expire_ready;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         running, tc, expire_valid, overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: timer described as mode + count + period + event flags.
    int           m_mode;
    int unsigned  m_count;
    int unsigned  m_period;
    bit           m_valid;
    bit           m_overrun;
    bit           m_tc;
    logic         tc_seen;

    vec_t vecs[$];

    count_down_timer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .load_value   (load_value),
        .preset       (preset),
        .enable       (enable),
        .auto_reload  (auto_reload),
        .count        (count),
        .running      (running),
        .tc           (tc),
        .expire_valid (expire_valid),
        .expire_ready (expire_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic stim_t mkStim(input logic r, input logic ld, input logic [W-1:0] lv,
                                     input logic pr, input logic en, input logic ar,
                                     input logic rdy);
        stim_t s;
        s.rst = r; s.load = ld; s.load_value = lv; s.preset = pr;
        s.enable = en; s.auto_reload = ar; s.expire_ready = rdy;
        return s;
    endfunction

    function automatic vec_t mkVec(input stim_t s, input logic t, input logic [W-1:0] c,
                                   input logic run, input logic v, input logic ov);
        vec_t x;
        x.stim = s; x.exp_tc = t; x.exp_count = c;
        x.exp_running = run; x.exp_valid = v; x.exp_overrun = ov;
        return x;
    endfunction

    function automatic bit modelTc(input stim_t s);
        return (m_mode == M_RUN) && s.enable && (m_count == 1) && !s.load && !s.preset;
    endfunction

    task automatic modelReset();
        m_mode = M_IDLE; m_count = 0; m_period = 0; m_valid = 0; m_overrun = 0;
    endtask

    // One clock of the timer's rules applied with plain arithmetic.
    task automatic modelStep(input stim_t s);
        bit fire;
        bit pending;
        if (s.rst) begin
            modelReset();
        end else begin
            fire    = modelTc(s);
            pending = m_valid && !s.expire_ready;
            if (s.load) begin
                m_count   = s.load_value;
                m_period  = s.load_value;
                m_overrun = 0;
                m_mode    = (s.load_value != 0) ? M_RUN : M_IDLE;
            end else if (s.preset) begin
                m_count = (1 << W) - 1;
            end else if (m_mode == M_RUN && m_count == 0) begin
                m_mode = M_EXP;
            end else if (fire) begin
                if (pending) m_overrun = 1;
                if (s.auto_reload) m_count = m_period;
                else begin
                    m_count = 0;
                    m_mode  = M_EXP;
                end
            end else if (m_mode == M_RUN && s.enable) begin
                m_count = (m_count + (1 << W) - 1) % (1 << W);
            end
            m_valid = fire || pending;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, records tc mid-cycle, then advances the model past the edge.
    task automatic applyStimulus(input stim_t s, output logic tc_mid);
        rst = s.rst; load = s.load; load_value = s.load_value; preset = s.preset;
        enable = s.enable; auto_reload = s.auto_reload; expire_ready = s.expire_ready;
        #1;
        tc_mid = tc;
        m_tc   = modelTc(s);
        @(posedge clk);
        modelStep(s);
        #1;
    endtask

    task automatic checkModel(input string tag, input logic tc_mid);
        checkOutput({tag, ".tc"}, 32'(tc_mid), 32'(m_tc));
        checkOutput({tag, ".count"}, 32'(count), m_count);
        checkOutput({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
        checkOutput({tag, ".expire_valid"}, 32'(expire_valid), 32'(m_valid));
        checkOutput({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    task automatic stepModel(input string tag, input stim_t s);
        logic t;
        applyStimulus(s, t);
        tc_seen = t;
        checkModel(tag, t);
    endtask

    initial begin
        stim_t idle_s;
        int    en_cycles;
        bit    seen;

        rst = 1; load = 0; load_value = '0; preset = 0;
        enable = 0; auto_reload = 0; expire_ready = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.count", 32'(count), 32'd0);
        checkOutput("reset.running", 32'(running), 32'd0);
        checkOutput("reset.tc", 32'(tc), 32'd0);
        checkOutput("reset.expire_valid", 32'(expire_valid), 32'd0);
        checkOutput("reset.overrun", 32'(overrun), 32'd0);

        // Vector table: inputs for one cycle, tc during it, registered outputs after it.
        vecs.push_back(mkVec(mkStim(0,1,16'd3,0,1,0,0),    0, 16'd3,    1, 0, 0));
        vecs.push_back(mkVec(mkStim(0,0,16'd0,0,1,0,0),    0, 16'd2,    1, 0, 0));
        vecs.push_back(mkVec(mkStim(0,0,16'd0,0,1,0,0),    0, 16'd1,    1, 0, 0));
        vecs.push_back(mkVec(mkStim(0,0,16'd0,0,1,0,0),    1, 16'd0,    0, 1, 0));
        vecs.push_back(mkVec(mkStim(0,0,16'd0,0,1,0,0),    0, 16'd0,    0, 1, 0));
        vecs.push_back(mkVec(mkStim(0,0,16'd0,0,1,0,1),    0, 16'd0,    0, 0, 0));
        vecs.push_back(mkVec(mkStim(0,0,16'd0,1,1,0,0),    0, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mkVec(mkStim(0,1,16'h00FF,1,0,0,0), 0, 16'h00FF, 1, 0, 0));
        vecs.push_back(mkVec(mkStim(0,1,16'd1,0,0,0,0),    0, 16'd1,    1, 0, 0));
        vecs.push_back(mkVec(mkStim(0,1,16'h00FF,0,1,0,0), 0, 16'h00FF, 1, 0, 0));
        vecs.push_back(mkVec(mkStim(1,1,16'd7,0,1,0,0),    0, 16'd0,    0, 0, 0));
        vecs.push_back(mkVec(mkStim(0,0,16'd0,1,1,0,0),    0, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mkVec(mkStim(0,1,16'd0,0,1,0,0),    0, 16'd0,    0, 0, 0));

        foreach (vecs[i]) begin
            logic t;
            applyStimulus(vecs[i].stim, t);
            checkOutput($sformatf("vec%0d.tc", i), 32'(t), 32'(vecs[i].exp_tc));
            checkOutput($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d.running", i), 32'(running), 32'(vecs[i].exp_running));
            checkOutput($sformatf("vec%0d.valid", i), 32'(expire_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d.overrun", i), 32'(overrun), 32'(vecs[i].exp_overrun));
        end

        idle_s = mkStim(0,0,16'd0,0,1,0,0);

        // One-shot expiry then ten cycles parked at zero.
        stepModel("os.rst", mkStim(1,0,16'd0,0,0,0,0));
        stepModel("os.load", mkStim(0,1,16'd3,0,1,0,0));
        repeat (3) stepModel("os.run", idle_s);
        for (int i = 0; i < 10; i++) begin
            stepModel("os.hold", idle_s);
            checkOutput("os.hold_count", 32'(count), 32'd0);
            checkOutput("os.hold_running", 32'(running), 32'd0);
        end

        // Auto-reload period 2 with consumer always ready.
        stepModel("ar.rst", mkStim(1,0,16'd0,0,0,0,0));
        stepModel("ar.load", mkStim(0,1,16'd2,0,1,1,1));
        for (int i = 0; i < 8; i++) begin
            stepModel("ar.run", mkStim(0,0,16'd0,0,1,1,1));
            checkOutput("ar.pattern", 32'(count), (i % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput("ar.tc_period", 32'(tc_seen), 32'(i % 2 == 1));
        end
        checkOutput("ar.overrun", 32'(overrun), 32'd0);

        // Overrun with period 1 and no consumer, then cleared by a load.
        stepModel("ov.rst", mkStim(1,0,16'd0,0,0,0,0));
        stepModel("ov.load", mkStim(0,1,16'd1,0,0,1,0));
        stepModel("ov.exp1", mkStim(0,0,16'd0,0,1,1,0));
        checkOutput("ov.first_valid", 32'(expire_valid), 32'd1);
        checkOutput("ov.first_overrun", 32'(overrun), 32'd0);
        stepModel("ov.exp2", mkStim(0,0,16'd0,0,1,1,0));
        checkOutput("ov.second_overrun", 32'(overrun), 32'd1);
        stepModel("ov.reload", mkStim(0,1,16'd4,0,0,1,0));
        checkOutput("ov.load_clears", 32'(overrun), 32'd0);
        checkOutput("ov.valid_held", 32'(expire_valid), 32'd1);
        stepModel("ov.ack", mkStim(0,0,16'd0,0,0,1,1));
        checkOutput("ov.ack_clears", 32'(expire_valid), 32'd0);

        // Period 5 with enable toggling: expiry after exactly five enabled cycles.
        stepModel("en.rst", mkStim(1,0,16'd0,0,0,0,0));
        stepModel("en.load", mkStim(0,1,16'd5,0,0,0,0));
        en_cycles = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            stepModel("en.run", mkStim(0,0,16'd0,0,(i % 2 == 0),0,0));
            if (i % 2 == 0) en_cycles++;
            if (tc_seen === 1'b1) seen = 1;
        end
        checkOutput("en.expired", 32'(seen), 32'd1);
        checkOutput("en.enabled_cycles", en_cycles, 32'd5);

        // Randomised run against the reference model.
        stepModel("rnd.rst", mkStim(1,0,16'd0,0,0,0,0));
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            logic [W-1:0] lv;
            lv = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            s = mkStim($urandom_range(0, 79) == 0, $urandom_range(0, 11) == 0, lv,
                       $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            stepModel("rnd", s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_down_timer.md
Name: count_down_timer

Overview:
- Loadable 16-bit down-counter/timer: the consumer-side counterpart of the team's loadable up-counter next-state block.
- Software or a controller loads a period. The block decrements while enabled and signals expiry through a valid/ready event handshake.
- Optional auto-reload for periodic ticks. Cascadable through enable (borrow-in) and tc (borrow-out).

Parameters:
WIDTH, 16, counter and load-value width in bits (minimum 2)

Ports:
clk  input  1  single system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  load load_value into count and the reload register
load_value  input  WIDTH  period to load
preset  input  1  force count to all ones
enable  input  1  count enable / borrow-in
auto_reload  input  1  on expiry, reload the period instead of stopping
count  output  WIDTH  current counter value (registered)
running  output  1  high in RUN state (registered)
tc  output  1  combinational terminal count: expiry occurs this cycle (borrow-out)
expire_valid  output  1  expiry event pending (registered)
expire_ready  input  1  consumer acknowledges expiry event
overrun  output  1  sticky: an expiry occurred while an event was still unacknowledged

Behaviour:
- Reset values: count=0, reload register=0, state IDLE, running=0, expire_valid=0, overrun=0. tc=0 follows from IDLE.
- States: IDLE, RUN, EXPIRED. running=1 only in RUN.
- Priority per cycle: rst > load > preset > decrement.
- load: count<=load_value and reload<=load_value; overrun<=0.
  - load_value!=0: next state RUN.
  - load_value==0: next state IDLE, no event.
  - Any in-flight expiry in the same cycle is discarded. expire_valid is unchanged except that a same-cycle expire_ready still clears it.
- preset (no load): count<=all ones; state and reload register unchanged. In RUN, no decrement that cycle.
- IDLE and EXPIRED: count holds; enable ignored; no wrap below 0.
- RUN, enable=1, count>1: count<=count-1.
- RUN, enable=1, count==1: expiry.
  - tc=1 this cycle (tc = RUN & enable & count==1 & !load & !preset).
  - auto_reload=1: count<=reload; stay in RUN.
  - auto_reload=0: count<=0; next state EXPIRED.
- RUN, count==0 (reachable only via preset wrap; not possible): treated as count==1 is not required. Implementation must hold count at 0 and go to EXPIRED without an event.
- Latency: expire_valid rises the cycle after tc=1. A period of N gives exactly N enabled cycles between load and expiry.
- Event handshake:
  - expire_valid sets on expiry and stays high until a cycle with expire_ready=1, after which it clears.
  - expire_ready while expire_valid=0 is ignored.
- Expiry while expire_valid=1:
  - With expire_ready=1 the same cycle: expire_valid stays 1 (new event); overrun unchanged.
  - With expire_ready=0: overrun<=1; expire_valid stays 1.
  - overrun clears only on rst or load.
- Reset mid-count: all state returns to reset values the next cycle, regardless of other inputs.
- Arithmetic: unsigned modulo-2^WIDTH decrement; no signed interpretation.

Decomposition:
- Package count_pkg:
  - state enum (IDLE, RUN, EXPIRED)
  - default WIDTH constant
  - all-ones constant helper
- Sub-module count_down_next: purely combinational next-count/tc logic (decrement, reload select, preset, load priority).
- Top level holds the registers, FSM and handshake.

Test Plan:
- rst, then load=1 with load_value=3, enable=1 continuously, auto_reload=0 -> count 3,2,1,0. tc=1 in the count==1 cycle. expire_valid=1 one cycle later. State EXPIRED with count held at 0 for 10 further cycles.
- load_value=2, auto_reload=1, enable=1, expire_ready=1 always -> count 2,1,2,1,... with tc every 2nd cycle. expire_valid pulses one cycle per expiry. overrun stays 0.
- load_value=1, auto_reload=1, enable=1, expire_ready=0 -> first expiry sets expire_valid; second expiry sets overrun=1. A subsequent load clears overrun, while expire_valid remains 1 until expire_ready is asserted.
- load_value=5, enable toggling 1,0,1,0... -> count decrements only on enabled cycles. Expiry occurs after exactly 5 enabled cycles.
- count==1 in RUN with enable=1, and load=1 with load_value=0x00FF in the same cycle -> tc=0, no event, count=0x00FF, state RUN. Separately: preset=1 in IDLE -> count=0xFFFF, running=0.
- Mid-count rst=1 with load=1 also asserted -> next cycle count=0, running=0, expire_valid=0, overrun=0.
